// File: rtl/traffic_pkg.sv
// Shared constants and helpers for the lane traffic generator.
package traffic_pkg;

  localparam int   LEVEL_W   = 4;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Effective lane period: base minus level, never below one tick.
  function automatic logic [3:0] eff_period(input logic [3:0] base,
                                            input logic [LEVEL_W-1:0] level);
    logic signed [4:0] d;
    d = $signed({1'b0, base}) - $signed({1'b0, level});
    return (d < 5'sd1) ? 4'd1 : d[3:0];
  endfunction

  // Cars of a lane start evenly spaced across the grid.
  function automatic int reset_x(input int k, input int cars, input int grid_w);
    return k * (grid_w / cars);
  endfunction

endpackage

// File: rtl/lane_step_timer.sv
// Per-lane tick down-counter; strobes step when it expires on a tick and reloads.
module lane_step_timer
  import traffic_pkg::*;
(
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               tick,
  input  logic [3:0]         base,
  input  logic [LEVEL_W-1:0] level,
  output logic               step
);

  logic [3:0] cnt;

  assign step = tick && (cnt == 4'd0);

  // Reload samples the level current on the step cycle; a running count is never cut short.
  always_ff @(posedge i_Clk) begin
    if (i_Rst)     cnt <= eff_period(base, '0) - 4'd1;
    else if (tick) cnt <= (cnt == 4'd0) ? eff_period(base, level) - 4'd1 : cnt - 4'd1;
  end

endmodule

// File: rtl/lane_traffic_ctrl.sv
// Multi-lane traffic generator: prescaler, level, car positions with wrap, collision flag.
// Optional build macro TRAFFIC_COLLISION_EN enables the frog comparator bank and sticky o_Hit.
module lane_traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int                       NUM_LANES     = 5,
  parameter int                       CARS_PER_LANE = 2,
  parameter int                       GRID_W        = 20,
  parameter int                       COORD_W       = 6,
  parameter int                       LANE_Y0       = 8,
  parameter logic [NUM_LANES-1:0]     LANE_DIR      = 5'b10101,
  parameter logic [NUM_LANES*4-1:0]   LANE_PERIOD   = {5{4'd4}},
  parameter int                       TICK_COUNT    = 700000,
  parameter int                       TICK_W        = 21
) (
  input  logic                                       i_Clk,
  input  logic                                       i_Rst,
  input  logic                                       i_Run,
  input  logic                                       i_Level_Up,
  input  logic                                       i_Hit_Clr,
  input  logic [COORD_W-1:0]                         i_Frog_X,
  input  logic [COORD_W-1:0]                         i_Frog_Y,
  output logic [NUM_LANES*CARS_PER_LANE*COORD_W-1:0] o_Car_X,
  output logic [NUM_LANES*CARS_PER_LANE*COORD_W-1:0] o_Car_Y,
  output logic [LEVEL_W-1:0]                         o_Level,
  output logic                                       o_Tick,
  output logic                                       o_Hit
);

  localparam int NCARS = NUM_LANES * CARS_PER_LANE;

  logic [TICK_W-1:0]    presc;
  logic                 tick_q;
  logic [LEVEL_W-1:0]   level;
  logic [NUM_LANES-1:0] step;
  logic [NCARS-1:0]     match;
  logic                 lane_tick;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      presc  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (i_Run) begin
        if (presc == TICK_W'(TICK_COUNT - 1)) begin
          presc  <= '0;
          tick_q <= 1'b1;
        end else begin
          presc  <= presc + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst)                                  level <= '0;
    else if (i_Level_Up && (level != '1))       level <= level + 1'b1;
  end

  // A tick landing while paused must not advance counters or positions.
  assign lane_tick = tick_q & i_Run;
  assign o_Tick    = tick_q;
  assign o_Level   = level;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lane_step_timer u_timer (
      .i_Clk (i_Clk),
      .i_Rst (i_Rst),
      .tick  (lane_tick),
      .base  (LANE_PERIOD[l*4 +: 4]),
      .level (level),
      .step  (step[l])
    );

    for (genvar k = 0; k < CARS_PER_LANE; k++) begin : g_car
      localparam int                 C     = l * CARS_PER_LANE + k;
      localparam logic [COORD_W-1:0] RST_X = COORD_W'(reset_x(k, CARS_PER_LANE, GRID_W));
      localparam logic [COORD_W-1:0] ROW_Y = COORD_W'(LANE_Y0 + l);
      localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);

      logic [COORD_W-1:0] x_q;
      logic [COORD_W-1:0] x_nxt;

      always_comb begin
        x_nxt = x_q;
        if (LANE_DIR[l] == DIR_RIGHT) x_nxt = (x_q == X_MAX) ? '0 : x_q + 1'b1;
        else                          x_nxt = (x_q == '0) ? X_MAX : x_q - 1'b1;
      end

      always_ff @(posedge i_Clk) begin
        if (i_Rst)        x_q <= RST_X;
        else if (step[l]) x_q <= x_nxt;
      end

      assign o_Car_X[C*COORD_W +: COORD_W] = x_q;
      assign o_Car_Y[C*COORD_W +: COORD_W] = ROW_Y;

`ifdef TRAFFIC_COLLISION_EN
      assign match[C] = (x_q == i_Frog_X) && (ROW_Y == i_Frog_Y);
`else
      assign match[C] = 1'b0;
`endif
    end
  end

`ifdef TRAFFIC_COLLISION_EN
  logic hit_q;

  // A new match beats a same-cycle clear so a collision is never lost.
  always_ff @(posedge i_Clk) begin
    if (i_Rst)          hit_q <= 1'b0;
    else if (|match)    hit_q <= 1'b1;
    else if (i_Hit_Clr) hit_q <= 1'b0;
  end

  assign o_Hit = hit_q;
`else
  logic unused_hit_inputs;
  assign unused_hit_inputs = ^{i_Frog_X, i_Frog_Y, i_Hit_Clr, match};
  assign o_Hit = 1'b0;
`endif

endmodule

// File: doc/lane_traffic_ctrl.md
# lane_traffic_ctrl

Parametrised multi-lane traffic generator for the road section of the playfield. Moves `NUM_LANES × CARS_PER_LANE` cars one grid cell per lane step, with per-lane direction and per-lane step period, wrap-around at the grid edges, and a saturating difficulty level that shortens every lane's period. It flags a hit when any car occupies the frog's cell. Output buses feed the sprite/renderer unchanged; the frog controller consumes `o_Hit`.

## Interface
- `NUM_LANES`, 5: number of lanes. Lane l occupies row `LANE_Y0 + l`.
- `CARS_PER_LANE`, 2: cars per lane.
- `GRID_W`, 20: columns; X range 0..GRID_W-1.
- `COORD_W`, 6: width of each coordinate field.
- `LANE_Y0`, 8: row of lane 0.
- `LANE_DIR`, 5'b10101: bit l=1 means lane l moves right (+X); 0 means left.
- `LANE_PERIOD`, {5{4'd4}}: 4-bit base period per lane, in ticks; field l at `[l*4 +: 4]`.
- `TICK_COUNT`, 700000: clocks per tick.
- `TICK_W`, 21: prescaler width.
- `i_Clk` in 1: system clock.
- `i_Rst` in 1: reset. One clock domain; reset is synchronous and active-high.
- `i_Run` in 1: when high, the prescaler advances. When low, all motion freezes.
- `i_Level_Up` in 1: single-cycle pulse. Increments the level.
- `i_Hit_Clr` in 1: clears the sticky hit flag.
- `i_Frog_X` in COORD_W: frog column.
- `i_Frog_Y` in COORD_W: frog row.
- `o_Car_X` out NUM_LANES·CARS_PER_LANE·COORD_W: car c = l·CARS_PER_LANE + k at `[c*COORD_W +: COORD_W]`.
- `o_Car_Y` out same width: same indexing as `o_Car_X`.
- `o_Level` out 4: current level, 0..15.
- `o_Tick` out 1: one-cycle strobe on each tick.
- `o_Hit` out 1: sticky collision flag.

## Operation
- **Reset values**
  - Prescaler = 0, `o_Tick` = 0, `o_Level` = 0, `o_Hit` = 0.
  - Lane counters = effective period − 1.
  - Car k of lane l: X = k·(GRID_W / CARS_PER_LANE), integer division; Y = LANE_Y0 + l.
  - Y never changes.
- **Prescaler**
  - While `i_Run` is high, it counts 0..TICK_COUNT−1.
  - On TICK_COUNT−1 it returns to 0 and asserts `o_Tick` for that cycle's successor, i.e. `o_Tick` is registered.
- **Effective period** per lane: P_l = max(1, LANE_PERIOD[l] − level).
  - Base 0 is treated as 1.
  - Arithmetic is 5-bit signed or saturating, with no underflow.
- **Lane counter**
  - On each tick it decrements.
  - When it is 0 on a tick, the lane steps and the counter reloads with P_l − 1, using the level value current in that cycle.
- **Step** (all cars of the lane update in the same cycle)
  - Right: X = GRID_W−1 → 0, else X+1.
  - Left: X = 0 → GRID_W−1, else X−1.
  - No X ever leaves 0..GRID_W−1.
- **Level**
  - `i_Level_Up` increments the level, saturating at 15.
  - A new level affects only subsequent reloads; a counter already counting is not truncated.
- **Hit**
  - Compare `i_Frog_X`/`i_Frog_Y` against all registered car positions every cycle.
  - Any match sets `o_Hit` on the next edge. It stays set until `i_Hit_Clr` or reset.
  - If a set and `i_Hit_Clr` occur in the same cycle, set wins.
- **`i_Run` low**: prescaler, counters and positions hold. Level and hit logic remain active.

## Timing
- Car position update latency: 1 clock after the tick strobe cycle. The position change and the counter reload occur on the same edge.
- Hit latency: 1 clock from the cycle in which registered positions and frog inputs match.
- `i_Rst` asserted mid-tick or mid-step: every register takes its reset value at the next edge. No step is committed on that edge.
- `i_Level_Up` and a lane reload on the same cycle: the reload uses the old level. The new level is visible on `o_Level` one clock later.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `TRAFFIC_COLLISION_EN`
  - Defined: the comparator bank and sticky `o_Hit` are built as above.
  - Undefined: `o_Hit` is tied to 0. Frog and `i_Hit_Clr` inputs are ignored, and no comparator logic is synthesised.

## Structure
- Package `traffic_pkg` holds:
  - Constants `DIR_LEFT` = 0 and `DIR_RIGHT` = 1.
  - The 4-bit level width.
  - A function computing effective period.
  - A function computing a reset X from k, CARS_PER_LANE and GRID_W.
- Sub-module `lane_step_timer`: one per lane, generated.
  - Inputs: tick, base period, level, reset.
  - Output: a one-cycle step strobe.
- The top level owns the prescaler, level register, position registers, wrap logic and collision logic.

## Test plan
All scenarios use TICK_COUNT = 4.
- **Reset**: assert `i_Rst` for 2 cycles, then check lane 0 car 0 X = 0 and car 1 X = 10, Y = 8; lane 4 Y = 12; `o_Level` = 0; `o_Hit` = 0.
- **Right wrap**: lane 0 period 1, car at X = 19. After the next tick, X = 0 one clock after `o_Tick`. A left lane at X = 0 goes to 19.
- **Period and level**: lane period 4 steps every 16 clocks. After three `i_Level_Up` pulses, it steps every 4 clocks from the next reload. Sixteen more pulses leave `o_Level` = 15 and the period = 1.
- **Freeze**: with `i_Run` = 0 for 50 cycles, positions and the prescaler are unchanged. Resuming produces the first tick 4 clocks later.
- **Hit**: frog at (10, 8), car 1 of lane 0 at (10, 8). `o_Hit` = 1 next clock and holds until `i_Hit_Clr`. With the same-cycle set/clear, it stays 1. With the macro undefined, `o_Hit` stays 0.
- **Mid-operation reset**: assert `i_Rst` in the same cycle as a step. Positions return to reset values with no step applied.
